sprscan_ctrl: RTL

//  Per-scanline sprite evaluator. Sequences the sprite-attribute RAM read port (spr_sel)

---
 rtl/spr_pkg.sv | 39 +++
 rtl/sprscan_ctrl_if.sv | 48 ++++
 rtl/sprscan_fifo.sv | 73 +++++++
 rtl/sprscan_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/spr_pkg.sv
// -----------------------------------------------------------------------------
// spr_pkg
//   Shared constants and types for the per-scanline sprite evaluator.
//
//   Contents
//     NUM_SPRITES / SPR_SEL_W : sprite-attribute table size and address width
//     HIT_W and HIT_*         : width and bit positions of one hit record
//                               {priority, palette[1:0], hflip, row[2:0],
//                                idx[8:0], x[8:0]}
//     state_t                 : evaluator state encoding
//
//   Configuration macro: SPRSCAN_REVERSE_EN is consumed by sprscan_ctrl (scan
//   order); nothing in this package depends on it.
// -----------------------------------------------------------------------------
package spr_pkg;

  localparam int NUM_SPRITES = 64;
  localparam int SPR_SEL_W   = 6;

  // Hit record layout, LSB first.
  localparam int HIT_X_LSB     = 0;
  localparam int HIT_X_W       = 9;
  localparam int HIT_IDX_LSB   = 9;
  localparam int HIT_IDX_W     = 9;
  localparam int HIT_ROW_LSB   = 18;
  localparam int HIT_ROW_W     = 3;
  localparam int HIT_HFLIP_BIT = 21;
  localparam int HIT_PAL_LSB   = 22;
  localparam int HIT_PAL_W     = 2;
  localparam int HIT_PRI_BIT   = 24;
  localparam int HIT_W         = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no line requested since reset
    ST_SCAN = 2'd1,   // walking the attribute table, one entry per cycle
    ST_DONE = 2'd2    // every entry evaluated; FIFO may still be draining
  } state_t;

endpackage : spr_pkg

// File: rtl/sprscan_ctrl_if.sv
// -----------------------------------------------------------------------------
// sprscan_ctrl_if
//   Bundles the two buses of the sprite evaluator:
//     - the sprite-attribute RAM read port (address out, attributes back in the
//       same cycle through an asynchronous read),
//     - the hit-record stream towards the line-buffer renderer (valid/ready).
//
//   Modports
//     master : the evaluator (drives spr_sel and the hit stream)
//     slave  : the environment (attribute RAM + renderer)
// -----------------------------------------------------------------------------
interface sprscan_ctrl_if;
  import spr_pkg::*;

  // Attribute RAM read port
  logic [SPR_SEL_W-1:0] spr_sel;
  logic [8:0]           spr_x;
  logic [7:0]           spr_y;
  logic [8:0]           spr_idx;
  logic                 spr_enable;
  logic                 spr_priority;
  logic [1:0]           spr_palette;
  logic                 spr_h16;
  logic                 spr_vflip;
  logic                 spr_hflip;

  // Hit stream
  logic                 hit_valid;
  logic                 hit_ready;
  logic [HIT_W-1:0]     hit_data;

  modport master (
    output spr_sel,
    input  spr_x, spr_y, spr_idx, spr_enable, spr_priority,
    input  spr_palette, spr_h16, spr_vflip, spr_hflip,
    output hit_valid, hit_data,
    input  hit_ready
  );

  modport slave (
    input  spr_sel,
    output spr_x, spr_y, spr_idx, spr_enable, spr_priority,
    output spr_palette, spr_h16, spr_vflip, spr_hflip,
    input  hit_valid, hit_data,
    output hit_ready
  );

endinterface : sprscan_ctrl_if

// File: rtl/sprscan_fifo.sv
// -----------------------------------------------------------------------------
// sprscan_fifo
//   Synchronous FIFO holding hit records between the evaluator and the
//   renderer. Registered write: a pushed record appears at rdata one cycle
//   after the push. Head is read combinationally from the storage array, so
//   rdata is stable for as long as nothing is popped.
//
//   Ports
//     clk, reset  : clock, asynchronous active-high reset
//     flush       : drop every stored entry (wins over push and pop)
//     push, wdata : write request / record
//     pop         : remove head (ignored when empty)
//     rdata       : head record
//     full, empty : occupancy flags
//
//   A push on a full FIFO is accepted only when a pop happens in the same
//   cycle; otherwise it is ignored (the evaluator never issues one).
// -----------------------------------------------------------------------------
module sprscan_fifo #(
  parameter int DEPTH = 4,      // power of 2, >= 2
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are meaningful, and a reset-free array maps onto
  // plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule : sprscan_fifo

// File: rtl/sprscan_ctrl.sv
// -----------------------------------------------------------------------------
// sprscan_ctrl
//   Per-scanline sprite evaluator. On line_start it walks the 64-entry
//   sprite-attribute RAM, one entry per cycle, and queues a hit record for every
//   enabled sprite that covers the requested scanline. Records go through a
//   small FIFO to the sprite line-buffer renderer.
//
//   Ports
//     clk, reset   : clock, asynchronous active-high reset
//     line_start   : pulse, begin evaluating line_y (restarts a scan in progress)
//     line_y       : scanline to evaluate, sampled on line_start
//     scan_done    : all entries evaluated for the current line (registered)
//     overflow     : more than MAX_PER_LINE hits on the current line (sticky)
//     bus.master   : attribute RAM read port (spr_sel registered, attributes
//                    returned combinationally) and the hit valid/ready stream
//
//   Configuration
//     SPRSCAN_REVERSE_EN defined : scan 63 -> 0 (lowest index drawn last)
//     otherwise                  : scan 0 -> 63
// -----------------------------------------------------------------------------
module sprscan_ctrl
  import spr_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_PER_LINE = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  input  logic [7:0]    line_y,
  output logic          scan_done,
  output logic          overflow,
  sprscan_ctrl_if.master bus
);

  localparam int                   CNT_W   = $clog2(MAX_PER_LINE + 1);
  localparam logic [CNT_W-1:0]     CNT_ONE = 1;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_PER_LINE);
  localparam logic [SPR_SEL_W-1:0] SEL_ONE = 1;

  logic [SPR_SEL_W-1:0] next_sel;

`ifdef SPRSCAN_REVERSE_EN
  localparam logic [SPR_SEL_W-1:0] FIRST_SEL = SPR_SEL_W'(NUM_SPRITES - 1);
  localparam logic [SPR_SEL_W-1:0] LAST_SEL  = '0;
  assign next_sel = bus.spr_sel - SEL_ONE;
`else
  localparam logic [SPR_SEL_W-1:0] FIRST_SEL = '0;
  localparam logic [SPR_SEL_W-1:0] LAST_SEL  = SPR_SEL_W'(NUM_SPRITES - 1);
  assign next_sel = bus.spr_sel + SEL_ONE;
`endif

  state_t           state;
  logic [7:0]       line_y_q;
  logic [CNT_W-1:0] hit_cnt;

  // ---------------------------------------------------------------------------
  // Hit math on the entry currently addressed by spr_sel.
  // dy wraps mod 256, so a sprite near the bottom of the Y range also covers
  // the first lines of the next frame (y=250, 16 high -> 250..255, 0..9).
  // ---------------------------------------------------------------------------
  logic [7:0]       dy;
  logic [3:0]       h_m1;      // sprite height minus one (7 or 15)
  logic [3:0]       r;         // row inside the sprite after vertical flip
  logic             spr_hit;
  logic [8:0]       hit_idx;
  logic [HIT_W-1:0] hit_rec;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    hit_rec = '0;
    dy      = line_y_q - bus.spr_y;
    h_m1    = bus.spr_h16 ? 4'd15 : 4'd7;
    spr_hit = bus.spr_enable && (dy <= {4'b0000, h_m1});
    // Only meaningful on a hit, where dy < height so dy[3:0] is the full offset.
    r       = bus.spr_vflip ? (h_m1 - dy[3:0]) : dy[3:0];
    // Tall sprites are two stacked 8-line tiles; the lower half uses idx+1.
    hit_idx = (bus.spr_h16 && r[3]) ? (bus.spr_idx + 9'd1) : bus.spr_idx;

    hit_rec[HIT_X_LSB   +: HIT_X_W]   = bus.spr_x;
    hit_rec[HIT_IDX_LSB +: HIT_IDX_W] = hit_idx;
    hit_rec[HIT_ROW_LSB +: HIT_ROW_W] = r[2:0];
    hit_rec[HIT_HFLIP_BIT]            = bus.spr_hflip;
    hit_rec[HIT_PAL_LSB +: HIT_PAL_W] = bus.spr_palette;
    hit_rec[HIT_PRI_BIT]              = bus.spr_priority;
  end

  // ---------------------------------------------------------------------------
  // Scan control
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;
  logic fifo_room;
  logic hit_found;
  logic at_cap;
  logic want_push;
  logic fifo_push;
  logic advance;

  assign fifo_pop  = bus.hit_valid && bus.hit_ready;
  // A full FIFO still takes a record when the renderer pops in the same cycle.
  assign fifo_room = !fifo_full || fifo_pop;
  assign hit_found = (state == ST_SCAN) && spr_hit;
  assign at_cap    = (hit_cnt == CNT_MAX);
  assign want_push = hit_found && !at_cap;
  // line_start flushes the FIFO, so nothing from the old line may enter it.
  assign fifo_push = want_push && fifo_room && !line_start;
  // Hold spr_sel on a hit that cannot be stored yet; it is re-evaluated next
  // cycle so no record is lost. Hits beyond the per-line cap never stall.
  assign advance   = (state == ST_SCAN) && !(want_push && !fifo_room);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      bus.spr_sel <= '0;
      line_y_q  <= '0;
      hit_cnt   <= '0;
      scan_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (line_start) begin
      // Accepted in every state; a scan in progress is abandoned.
      state       <= ST_SCAN;
      bus.spr_sel <= FIRST_SEL;
      line_y_q    <= line_y;
      hit_cnt     <= '0;
      scan_done   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (fifo_push)          hit_cnt  <= hit_cnt + CNT_ONE;
          if (hit_found && at_cap) overflow <= 1'b1;
          if (advance) begin
            if (bus.spr_sel == LAST_SEL) begin
              scan_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              bus.spr_sel <= next_sel;
            end
          end
        end
        default: ;  // IDLE and DONE wait for line_start
      endcase
    end
  end

  sprscan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HIT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (line_start),
    .push  (fifo_push),
    .wdata (hit_rec),
    .pop   (fifo_pop),
    .rdata (bus.hit_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.hit_valid = !fifo_empty;

endmodule : sprscan_ctrl
